// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator.
// Sends the low `len` bits of `pat` MSB-first (bit len-1 .. bit 0), repeated
// rpt+1 times with `gap` idle cycles between transmissions, then pulses done.
// Every output is a flop; nothing passes combinationally from input to output.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - begin a transmission (sampled only while busy=0)
//   abort  - cancel the transmission in progress
//   pat    - pattern bits
//   len    - pattern length in bits, legal 1..MAXLEN
//   rpt    - extra repeat count (rpt+1 transmissions)
//   gap    - idle cycles between transmissions
//   seqout - serial data bit (0 when valid=0)
//   valid  - seqout carries a pattern bit
//   busy   - transmission or gap in progress
//   done   - one-cycle pulse on normal completion
//   err    - one-cycle pulse on a rejected start
module seq_gen #(
    parameter int MAXLEN = 8,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] pat,
    input  logic [CW-1:0]     len,
    input  logic [CW-1:0]     rpt,
    input  logic [CW-1:0]     gap,
    output logic              seqout,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_t;

    state_t            state, state_n;
    logic [MAXLEN-1:0] pat_q, pat_n;
    logic [CW-1:0]     len_q, len_n;
    logic [CW-1:0]     rpt_q, rpt_n;   // transmissions still to start after the current one
    logic [CW-1:0]     gap_q, gap_n;
    logic [CW-1:0]     idx_q, idx_n;   // index of the bit currently on seqout
    logic [CW-1:0]     gcnt_q, gcnt_n; // gap cycles remaining, including the current one
    logic              seqout_n, valid_n, busy_n, done_n, err_n;
    logic              len_ok;

    // Shift instead of a variable bit-select so the index width need not
    // match the pattern width.
    function automatic logic pick(input logic [MAXLEN-1:0] p, input logic [CW-1:0] i);
        logic [MAXLEN-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_ok = (len != '0) && (len <= CW'(MAXLEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pat_q  <= '0;
            len_q  <= '0;
            rpt_q  <= '0;
            gap_q  <= '0;
            idx_q  <= '0;
            gcnt_q <= '0;
            seqout <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            pat_q  <= pat_n;
            len_q  <= len_n;
            rpt_q  <= rpt_n;
            gap_q  <= gap_n;
            idx_q  <= idx_n;
            gcnt_q <= gcnt_n;
            seqout <= seqout_n;
            valid  <= valid_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

    // Next state and the output values for the next cycle are decided together,
    // which keeps the outputs registered while still showing the first bit
    // one cycle after start is sampled.
    always_comb begin
        state_n  = state;
        pat_n    = pat_q;
        len_n    = len_q;
        rpt_n    = rpt_q;
        gap_n    = gap_q;
        idx_n    = idx_q;
        gcnt_n   = gcnt_q;
        seqout_n = 1'b0;
        valid_n  = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;

        case (state)
            IDLE, FIN: begin
                state_n = IDLE;
                if (start) begin
                    if (len_ok) begin
                        pat_n    = pat;
                        len_n    = len;
                        rpt_n    = rpt;
                        gap_n    = gap;
                        idx_n    = len - CW'(1);
                        gcnt_n   = '0;
                        state_n  = SHIFT;
                        seqout_n = pick(pat, len - CW'(1));
                        valid_n  = 1'b1;
                        busy_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (idx_q != '0) begin
                    idx_n    = idx_q - CW'(1);
                    seqout_n = pick(pat_q, idx_q - CW'(1));
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
                end else if (rpt_q == '0) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                end else begin
                    rpt_n = rpt_q - CW'(1);
                    if (gap_q != '0) begin
                        state_n = GAP;
                        gcnt_n  = gap_q;
                        busy_n  = 1'b1;
                    end else begin
                        idx_n    = len_q - CW'(1);
                        seqout_n = pick(pat_q, len_q - CW'(1));
                        valid_n  = 1'b1;
                        busy_n   = 1'b1;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gcnt_q == CW'(1)) begin
                    state_n  = SHIFT;
                    idx_n    = len_q - CW'(1);
                    seqout_n = pick(pat_q, len_q - CW'(1));
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
                end else begin
                    gcnt_n = gcnt_q - CW'(1);
                    busy_n = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: self-checking bench for seq_gen (MAXLEN=8, CW=4).
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus compared against a queue-based model of the expected output stream.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] rpt;
    logic [3:0] gap;
    logic       seqout, valid, busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    seq_gen #(.MAXLEN(8), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .pat   (pat),
        .len   (len),
        .rpt   (rpt),
        .gap   (gap),
        .seqout(seqout),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {seqout, valid, busy, done, err}.
    typedef struct {
        logic       start;
        logic       abort;
        logic [7:0] pat;
        logic [3:0] len;
        logic [3:0] rpt;
        logic [3:0] gap;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[25];

    logic [4:0] mq[$];   // model: expected outputs for upcoming cycles
    logic [4:0] m_cur;
    logic [4:0] m_nxt;

    function automatic vec_t mk(input int s, input int a, input int p, input int l,
                                input int r, input int g, input logic [4:0] e);
        vec_t v;
        v.start = s[0];
        v.abort = a[0];
        v.pat   = p[7:0];
        v.len   = l[3:0];
        v.rpt   = r[3:0];
        v.gap   = g[3:0];
        v.exp   = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {seqout, valid, busy, done, err};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {seqout,valid,busy,done,err}=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic go(input int p, input int l, input int r, input int g);
        pat   = p[7:0];
        len   = l[3:0];
        rpt   = r[3:0];
        gap   = g[3:0];
        start = 1'b1;
    endtask

    // Clock n cycles; start/abort drop after the first edge. Streams are
    // MSB = first cycle checked; err is expected low throughout.
    task automatic play(input string nm, input int n, input logic [31:0] s,
                        input logic [31:0] v, input logic [31:0] b, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            chk($sformatf("%s_c%0d", nm, i + 1), {s[n-1-i], v[n-1-i], b[n-1-i], d[n-1-i], 1'b0});
        end
    endtask

    // Whole expected output stream of an accepted start, derived from the
    // pattern/repeat/gap rules rather than from any state machine.
    task automatic model_load(input logic [7:0] p, input int l, input int r, input int g);
        mq.delete();
        for (int t = 0; t <= r; t++) begin
            for (int bi = l - 1; bi >= 0; bi--) mq.push_back({p[bi], 4'b1100});
            if (t < r) for (int k = 0; k < g; k++) mq.push_back(5'b00100);
        end
        mq.push_back(5'b00010);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pat = '0; len = '0; rpt = '0; gap = '0;
        start = 1'b1; abort = 1'b1; len = 4'd3; pat = 8'hFF;
        tick();
        tick();
        chk("reset", 5'b00000);
        start = 1'b0; abort = 1'b0;
        rst = 1'b0;

        tbl[0]  = mk(1, 0, 8'h05, 0, 0, 0, 5'b00001);
        tbl[1]  = mk(0, 0, 8'h00, 0, 0, 0, 5'b00000);
        tbl[2]  = mk(1, 0, 8'h05, 9, 0, 0, 5'b00001);
        tbl[3]  = mk(1, 0, 8'h05, 15, 0, 0, 5'b00001);
        tbl[4]  = mk(1, 1, 8'h05, 3, 0, 0, 5'b11100);
        tbl[5]  = mk(0, 0, 8'h00, 0, 0, 0, 5'b01100);
        tbl[6]  = mk(1, 0, 8'h00, 0, 0, 0, 5'b11100);
        tbl[7]  = mk(0, 0, 8'h00, 0, 0, 0, 5'b00010);
        tbl[8]  = mk(1, 0, 8'h05, 0, 0, 0, 5'b00001);
        tbl[9]  = mk(0, 0, 8'h00, 0, 0, 0, 5'b00000);
        tbl[10] = mk(0, 1, 8'h00, 0, 0, 0, 5'b00000);
        tbl[11] = mk(1, 0, 8'hFF, 1, 2, 0, 5'b11100);
        tbl[12] = mk(0, 0, 8'h00, 0, 0, 0, 5'b11100);
        tbl[13] = mk(0, 0, 8'h00, 0, 0, 0, 5'b11100);
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 0, 5'b00010);
        tbl[15] = mk(1, 0, 8'h80, 8, 0, 1, 5'b11100);
        for (int i = 16; i < 23; i++) tbl[i] = mk(0, 0, 8'h00, 0, 0, 0, 5'b01100);
        tbl[23] = mk(0, 0, 8'h00, 0, 0, 0, 5'b00010);
        tbl[24] = mk(0, 0, 8'h00, 0, 0, 0, 5'b00000);

        for (int i = 0; i < 25; i++) begin
            start = tbl[i].start; abort = tbl[i].abort; pat = tbl[i].pat;
            len = tbl[i].len; rpt = tbl[i].rpt; gap = tbl[i].gap;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end
        start = 1'b0; abort = 1'b0;

        go(8'h05, 3, 0, 0);
        play("single", 5, 32'b10100, 32'b11100, 32'b11100, 32'b00010);
        go(8'h05, 3, 1, 2);
        play("gap2", 10, 32'b1010010100, 32'b1110011100, 32'b1111111100, 32'b0000000010);
        go(8'h05, 3, 1, 0);
        play("nogap", 7, 32'b1011010, 32'b1111110, 32'b1111110, 32'b0000001);
        go(8'h05, 3, 0, 0);
        play("b2b", 5, 32'b10100, 32'b11100, 32'b11100, 32'b00010);

        go(8'hA5, 8, 0, 0);
        play("abt", 4, 32'b1010, 32'b1111, 32'b1111, 32'b0000);
        abort = 1'b1;
        play("abt_post", 4, 32'b0, 32'b0, 32'b0, 32'b0);

        go(8'h05, 3, 1, 3);
        play("rstgap", 4, 32'b1010, 32'b1110, 32'b1111, 32'b0000);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        play("rst_hit", 1, 32'b0, 32'b0, 32'b0, 32'b0);
        rst = 1'b0;
        go(8'h05, 3, 0, 0);
        play("post_rst", 5, 32'b10100, 32'b11100, 32'b11100, 32'b00010);

        go(8'hA5, 8, 0, 0);
        play("ign_a", 2, 32'b10, 32'b11, 32'b11, 32'b00);
        go(8'h3C, 3, 0, 0);
        play("ign_b", 8, 32'b10010100, 32'b11111100, 32'b11111100, 32'b00000010);

        go(8'h01, 1, 15, 0);
        play("rpt15", 18, {14'b0, 18'h3FFFC}, {14'b0, 18'h3FFFC}, {14'b0, 18'h3FFFC}, 32'b10);

        // Random phase: the DUT is idle here, so the model starts idle too.
        mq.delete();
        m_cur = 5'b00000;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            chk($sformatf("rnd%0d", cyc), m_cur);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 149) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            pat   = 8'($urandom);
            len   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            rpt   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            gap   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if (rst) begin
                mq.delete();
                m_nxt = 5'b00000;
            end else if (m_cur[2] && abort) begin
                mq.delete();
                m_nxt = 5'b00000;
            end else if (!m_cur[2] && start) begin
                if (len >= 4'd1 && len <= 4'd8) begin
                    model_load(pat, int'(len), int'(rpt), int'(gap));
                    m_nxt = mq.pop_front();
                end else begin
                    mq.delete();
                    m_nxt = 5'b00001;
                end
            end else begin
                m_nxt = (mq.size() > 0) ? mq.pop_front() : 5'b00000;
            end
            tick();
            m_cur = m_nxt;
        end
        chk("rnd_last", m_cur);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
